piradspi_cmd_arbiter: RTL and testbench

Shares one PiRadSPI engine between NUM_REQ independent command sources, e.g. several CSR front-ends or DMA sequencers.
- Arbitrates round-robin among requester command streams and forwards one command at a time to the engine's command AXI-Stream.
- Holds the grant until the engine reports transfer completion, so a transfer is never interleaved with another.
- While the grant is held, routes the engine's MISO stream back to the owning requester only.
- Sits between the requester front-ends and the engine's axis_cmd / axis_miso ports.

---
 rtl/piradspi_cmd_arbiter.sv | 158 +++++++++++++++
 tb/tb_piradspi_cmd_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piradspi_cmd_arbiter.sv
// Round-robin command arbiter sharing one PiRadSPI engine between NUM_REQ sources.
// Holds the grant from command issue until transfer completion (or timeout) and routes MISO to the owner.
module piradspi_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CMD_WIDTH      = 128,
  parameter int unsigned MISO_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TO_WIDTH       = 24,
  localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]  s_cmd_tdata,
  input  logic [NUM_REQ-1:0]            s_cmd_tvalid,
  output logic [NUM_REQ-1:0]            s_cmd_tready,
  output logic [CMD_WIDTH-1:0]          m_cmd_tdata,
  output logic                          m_cmd_tvalid,
  input  logic                          m_cmd_tready,
  input  logic                          xfer_done,
  input  logic [MISO_WIDTH-1:0]         s_miso_tdata,
  input  logic                          s_miso_tvalid,
  output logic                          s_miso_tready,
  output logic [MISO_WIDTH-1:0]         m_miso_tdata,
  output logic [NUM_REQ-1:0]            m_miso_tvalid,
  input  logic [NUM_REQ-1:0]            m_miso_tready,
  output logic                          grant_active,
  output logic [IDW-1:0]                grant_id,
  output logic                          timeout_err
);

  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic                  grant_active_q, grant_active_d;
  logic                  m_cmd_tvalid_q, m_cmd_tvalid_d;
  logic [CMD_WIDTH-1:0]  m_cmd_tdata_q, m_cmd_tdata_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  win_found;
  logic [IDW-1:0]        win_id;
  logic [CMD_WIDTH-1:0]  cmd_sel;
  logic                  timeout_hit;
  logic                  release_grant;
  int unsigned           idx;

  // Rotating priority search starting at rr_ptr with explicit wrap at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && s_cmd_tvalid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (IDW'(i) == win_id) cmd_sel = s_cmd_tdata[i*CMD_WIDTH +: CMD_WIDTH];
    end
  end

  assign timeout_hit   = TO_EN && (to_cnt_q == TO_LAST);
  assign release_grant = xfer_done || timeout_hit;

  // Next-state, register updates and the combinational handshake/passthrough outputs.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    m_cmd_tvalid_d = m_cmd_tvalid_q;
    m_cmd_tdata_d  = m_cmd_tdata_q;
    to_cnt_d       = to_cnt_q;
    timeout_err_d  = 1'b0;
    s_cmd_tready   = '0;
    s_miso_tready  = 1'b0;
    m_miso_tvalid  = '0;
    m_miso_tdata   = s_miso_tdata;
    case (state_q)
      ST_IDLE: begin
        if (aresetn && enable && win_found) begin
          s_cmd_tready[win_id] = 1'b1;
          m_cmd_tdata_d        = cmd_sel;
          m_cmd_tvalid_d       = 1'b1;
          grant_id_d           = win_id;
          grant_active_d       = 1'b1;
          state_d              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_cmd_tready) begin
          m_cmd_tvalid_d = 1'b0;
          to_cnt_d       = '0;
          state_d        = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        m_miso_tvalid[grant_id_q] = s_miso_tvalid;
        s_miso_tready             = m_miso_tready[grant_id_q];
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
        if (release_grant) begin
          grant_active_d = 1'b0;
          rr_ptr_d       = (32'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
          timeout_err_d  = timeout_hit && !xfer_done;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      m_cmd_tvalid_q <= 1'b0;
      m_cmd_tdata_q  <= '0;
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      m_cmd_tvalid_q <= m_cmd_tvalid_d;
      m_cmd_tdata_q  <= m_cmd_tdata_d;
      to_cnt_q       <= to_cnt_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign m_cmd_tdata  = m_cmd_tdata_q;
  assign m_cmd_tvalid = m_cmd_tvalid_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_piradspi_cmd_arbiter.sv
// Directed bench for piradspi_cmd_arbiter: grant order, back-pressure, MISO routing, timeout and reset.
module tb_piradspi_cmd_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 128;
  localparam int unsigned MW = 32;
  localparam int unsigned TO = 50;
  localparam int unsigned TW = 24;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              enable;
  logic [NR*CW-1:0]  s_cmd_tdata;
  logic [NR-1:0]     s_cmd_tvalid;
  logic [NR-1:0]     s_cmd_tready;
  logic [CW-1:0]     m_cmd_tdata;
  logic              m_cmd_tvalid;
  logic              m_cmd_tready;
  logic              xfer_done;
  logic [MW-1:0]     s_miso_tdata;
  logic              s_miso_tvalid;
  logic              s_miso_tready;
  logic [MW-1:0]     m_miso_tdata;
  logic [NR-1:0]     m_miso_tvalid;
  logic [NR-1:0]     m_miso_tready;
  logic              grant_active;
  logic [1:0]        grant_id;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  piradspi_cmd_arbiter #(
    .NUM_REQ(NR), .CMD_WIDTH(CW), .MISO_WIDTH(MW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(TW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .xfer_done(xfer_done),
    .s_miso_tdata(s_miso_tdata), .s_miso_tvalid(s_miso_tvalid), .s_miso_tready(s_miso_tready),
    .m_miso_tdata(m_miso_tdata), .m_miso_tvalid(m_miso_tvalid), .m_miso_tready(m_miso_tready),
    .grant_active(grant_active), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [CW-1:0] d);
    s_cmd_tdata[i*CW +: CW] = d;
  endtask

  localparam logic [CW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [CW-1:0] PAT_BP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  // Grant order after a fresh reset with all four requesting.
  logic [1:0]    rr_exp   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  // MISO table: data, per-requester ready, done, expected s_miso_tready.
  logic [MW-1:0] miso_dat [5] = '{32'h11, 32'h11, 32'h22, 32'h22, 32'h33};
  logic [NR-1:0] miso_rdy [5] = '{4'b1101, 4'b0010, 4'b0000, 4'b1111, 4'b0010};
  logic          miso_dn  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic          miso_srd [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    aresetn       = 1'b0;
    enable        = 1'b1;
    s_cmd_tdata   = '0;
    s_cmd_tvalid  = 4'b1111;
    m_cmd_tready  = 1'b0;
    xfer_done     = 1'b0;
    s_miso_tdata  = '0;
    s_miso_tvalid = 1'b0;
    m_miso_tready = '0;

    // Reset state, with requests pending to show nothing leaks through.
    #12;
    check("rst_tvalid", 128'(m_cmd_tvalid), 128'(0));
    check("rst_tdata", 128'(m_cmd_tdata), 128'(0));
    check("rst_active", 128'(grant_active), 128'(0));
    check("rst_gid", 128'(grant_id), 128'(0));
    check("rst_terr", 128'(timeout_err), 128'(0));
    check("rst_sready", 128'(s_cmd_tready), 128'(0));
    check("rst_misordy", 128'(s_miso_tready), 128'(0));
    s_cmd_tvalid = '0;
    #5 aresetn = 1'b1;
    tick();

    // Single requester 2.
    set_cmd(2, PAT_A5);
    s_cmd_tvalid = 4'b0100;
    m_cmd_tready = 1'b1;
    #1 check("single_sready", 128'(s_cmd_tready), 128'(4'b0100));
    tick();
    check("single_tvalid", 128'(m_cmd_tvalid), 128'(1));
    check("single_tdata", 128'(m_cmd_tdata), 128'(PAT_A5));
    check("single_gid", 128'(grant_id), 128'(2));
    check("single_active", 128'(grant_active), 128'(1));
    s_cmd_tvalid = '0;
    tick();
    check("single_hs_tvalid", 128'(m_cmd_tvalid), 128'(0));
    check("single_wait_active", 128'(grant_active), 128'(1));
    repeat (8) tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("single_done_active", 128'(grant_active), 128'(0));
    check("single_done_gid", 128'(grant_id), 128'(2));

    // Round-robin from a fresh pointer.
    aresetn = 1'b0;
    #2 aresetn = 1'b1;
    tick();
    for (int g = 0; g < 5; g++) begin
      s_cmd_tvalid = 4'b1111;
      #1 check($sformatf("rr%0d_sready", g), 128'(s_cmd_tready), 128'(4'b0001 << rr_exp[g]));
      tick();
      check($sformatf("rr%0d_gid", g), 128'(grant_id), 128'(rr_exp[g]));
      check($sformatf("rr%0d_issue_sready", g), 128'(s_cmd_tready), 128'(0));
      tick();
      check($sformatf("rr%0d_wait_sready", g), 128'(s_cmd_tready), 128'(0));
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
    end
    s_cmd_tvalid = '0;

    // Engine back-pressure: pointer is now 1, only requester 3 asks.
    set_cmd(3, PAT_BP);
    s_cmd_tvalid = 4'b1000;
    m_cmd_tready = 1'b0;
    #1 check("bp_sready", 128'(s_cmd_tready), 128'(4'b1000));
    tick();
    s_cmd_tvalid = 4'b0111;
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("bp%0d_tvalid", k), 128'(m_cmd_tvalid), 128'(1));
      check($sformatf("bp%0d_tdata", k), 128'(m_cmd_tdata), 128'(PAT_BP));
      check($sformatf("bp%0d_sready", k), 128'(s_cmd_tready), 128'(0));
      tick();
    end
    m_cmd_tready = 1'b1;
    s_cmd_tvalid = '0;
    #1;
    check("bp_last_tvalid", 128'(m_cmd_tvalid), 128'(1));
    check("bp_last_tdata", 128'(m_cmd_tdata), 128'(PAT_BP));
    tick();
    check("bp_hs_tvalid", 128'(m_cmd_tvalid), 128'(0));
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("bp_done_active", 128'(grant_active), 128'(0));

    // MISO routing to owner 1; pointer wrapped to 0.
    s_cmd_tvalid = 4'b0010;
    #1 check("miso_sready", 128'(s_cmd_tready), 128'(4'b0010));
    tick();
    s_cmd_tvalid  = '0;
    s_miso_tvalid = 1'b1;
    s_miso_tdata  = 32'h99;
    m_miso_tready = 4'b1111;
    #1;
    check("miso_issue_srdy", 128'(s_miso_tready), 128'(0));
    check("miso_issue_mvalid", 128'(m_miso_tvalid), 128'(0));
    tick();
    for (int c = 0; c < 5; c++) begin
      s_miso_tdata  = miso_dat[c];
      m_miso_tready = miso_rdy[c];
      xfer_done     = miso_dn[c];
      #1;
      check($sformatf("miso%0d_mvalid", c), 128'(m_miso_tvalid), 128'(4'b0010));
      check($sformatf("miso%0d_srdy", c), 128'(s_miso_tready), 128'(miso_srd[c]));
      check($sformatf("miso%0d_data", c), 128'(m_miso_tdata), 128'(miso_dat[c]));
      tick();
    end
    xfer_done     = 1'b0;
    m_miso_tready = 4'b1111;
    #1;
    check("miso_after_srdy", 128'(s_miso_tready), 128'(0));
    check("miso_after_mvalid", 128'(m_miso_tvalid), 128'(0));
    check("miso_after_active", 128'(grant_active), 128'(0));
    s_miso_tvalid = 1'b0;

    // Timeout: pointer 2, requester 0 wins and never sees done.
    s_cmd_tvalid = 4'b0001;
    #1 check("to_sready", 128'(s_cmd_tready), 128'(4'b0001));
    tick();
    s_cmd_tvalid = '0;
    tick();
    n = 0;
    while (n < 60 && !timeout_err) begin
      tick();
      n++;
    end
    check("to_cycles", 128'(n), 128'(50));
    check("to_active", 128'(grant_active), 128'(0));
    s_cmd_tvalid = 4'b0011;
    #1 check("to_next_sready", 128'(s_cmd_tready), 128'(4'b0010));
    tick();
    check("to_next_gid", 128'(grant_id), 128'(1));
    check("to_pulse_end", 128'(timeout_err), 128'(0));
    check("to_next_active", 128'(grant_active), 128'(1));

    // Async reset while in WAIT_DONE, then enable low blocks grants.
    s_cmd_tvalid = '0;
    tick();
    s_cmd_tvalid  = 4'b1111;
    enable        = 1'b0;
    s_miso_tvalid = 1'b1;
    m_miso_tready = 4'b1111;
    #1 check("ar_wait_srdy", 128'(s_miso_tready), 128'(1));
    #2 aresetn = 1'b0;
    #1;
    check("ar_active", 128'(grant_active), 128'(0));
    check("ar_gid", 128'(grant_id), 128'(0));
    check("ar_srdy", 128'(s_miso_tready), 128'(0));
    check("ar_mvalid", 128'(m_miso_tvalid), 128'(0));
    check("ar_sready", 128'(s_cmd_tready), 128'(0));
    #2 aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("dis%0d_active", k), 128'(grant_active), 128'(0));
      check($sformatf("dis%0d_tvalid", k), 128'(m_cmd_tvalid), 128'(0));
      check($sformatf("dis%0d_sready", k), 128'(s_cmd_tready), 128'(0));
    end
    enable = 1'b1;
    #1 check("en_sready", 128'(s_cmd_tready), 128'(4'b0001));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
